// File: rtl/video_timing_pkg.sv
// Mode constants and TMDS control symbols shared by the video output path.
package video_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;

  // DVI control-period symbols indexed by {vsync, hsync}
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_front;
    logic [11:0] h_sync;
    logic [11:0] h_back;
    logic [11:0] v_active;
    logic [11:0] v_front;
    logic [11:0] v_sync;
    logic [11:0] v_back;
    logic        hsync_pol;
    logic        vsync_pol;
  } vtg_mode_t;

  localparam vtg_mode_t VGA_MODE = '{
    h_active:  12'(VGA_H_ACTIVE),
    h_front:   12'(VGA_H_FRONT),
    h_sync:    12'(VGA_H_SYNC),
    h_back:    12'(VGA_H_BACK),
    v_active:  12'(VGA_V_ACTIVE),
    v_front:   12'(VGA_V_FRONT),
    v_sync:    12'(VGA_V_SYNC),
    v_back:    12'(VGA_V_BACK),
    hsync_pol: 1'b0,
    vsync_pol: 1'b0
  };

  function automatic logic [9:0] tmds_ctrl_symbol(input logic vsync, input logic hsync);
    case ({vsync, hsync})
      2'b00:   return TMDS_CTRL_00;
      2'b01:   return TMDS_CTRL_01;
      2'b10:   return TMDS_CTRL_10;
      default: return TMDS_CTRL_11;
    endcase
  endfunction

endpackage

// File: rtl/vtg_delay.sv
// WIDTH x DEPTH shift register with enable and synchronous reset to RESET_VAL.
// DEPTH = 0 degenerates to a wire.
module vtg_delay #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clk, rst, en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, sync/DE/strobe decode and an aligned output delay line.
// Define VTG_VSYNC_HALIGN_EN to move vsync edges onto the hsync leading edge.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 32'(VGA_MODE.h_active),
  parameter int unsigned H_FRONT    = 32'(VGA_MODE.h_front),
  parameter int unsigned H_SYNC     = 32'(VGA_MODE.h_sync),
  parameter int unsigned H_BACK     = 32'(VGA_MODE.h_back),
  parameter int unsigned V_ACTIVE   = 32'(VGA_MODE.v_active),
  parameter int unsigned V_FRONT    = 32'(VGA_MODE.v_front),
  parameter int unsigned V_SYNC     = 32'(VGA_MODE.v_sync),
  parameter int unsigned V_BACK     = 32'(VGA_MODE.v_back),
  parameter int unsigned HSYNC_POL  = 32'(VGA_MODE.hsync_pol),
  parameter int unsigned VSYNC_POL  = 32'(VGA_MODE.vsync_pol),
  parameter int unsigned PIPE_DELAY = 0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned XW      = $clog2(H_TOTAL),
  localparam int unsigned YW      = $clog2(V_TOTAL)
) (
  input  logic          pxl_clk,
  input  logic          rst,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        HS_ON    = 1'(HSYNC_POL);
  localparam logic        VS_ON    = 1'(VSYNC_POL);
  localparam int unsigned BW       = XW + YW + 5;
  localparam logic [BW-1:0] RST_BUNDLE = {XW'(0), YW'(0), ~HS_ON, ~VS_ON, 3'b000};

  if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 || V_FRONT == 0 || V_SYNC == 0 ||
      V_BACK == 0 || PIPE_DELAY > 15) begin : g_param_check
    $error("video_timing_gen: porch/sync must be nonzero and PIPE_DELAY <= 15");
  end

  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          hs_act_c, vs_act_c, de_c, ls_c, fs_c;
  logic [BW-1:0] bundle_c, bundle_q;

  // Raster position counters; y steps on the x wrap
  always_ff @(posedge pxl_clk) begin
    if (rst) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (en) begin
      if (cnt_x == XW'(H_TOTAL - 1)) begin
        cnt_x <= '0;
        cnt_y <= (cnt_y == YW'(V_TOTAL - 1)) ? '0 : cnt_y + YW'(1);
      end else begin
        cnt_x <= cnt_x + XW'(1);
      end
    end
  end

  always_comb begin
    de_c     = (cnt_x < XW'(H_ACTIVE)) && (cnt_y < YW'(V_ACTIVE));
    hs_act_c = (cnt_x >= XW'(HS_START)) && (cnt_x < XW'(HS_END));
`ifdef VTG_VSYNC_HALIGN_EN
    vs_act_c = ((cnt_y == YW'(VS_START)) && (cnt_x >= XW'(HS_START))) ||
               ((cnt_y >  YW'(VS_START)) && (cnt_y <  YW'(VS_END)))   ||
               ((cnt_y == YW'(VS_END))   && (cnt_x <  XW'(HS_START)));
`else
    vs_act_c = (cnt_y >= YW'(VS_START)) && (cnt_y < YW'(VS_END));
`endif
    ls_c     = (cnt_x == '0);
    fs_c     = ls_c && (cnt_y == '0);
    bundle_c = {cnt_x, cnt_y,
                hs_act_c ? HS_ON : ~HS_ON,
                vs_act_c ? VS_ON : ~VS_ON,
                de_c, ls_c, fs_c};
  end

  // First stage is the decode register; the rest is PIPE_DELAY alignment
  vtg_delay #(
    .WIDTH     (BW),
    .DEPTH     (PIPE_DELAY + 1),
    .RESET_VAL (RST_BUNDLE)
  ) u_delay (
    .clk (pxl_clk),
    .rst (rst),
    .en  (en),
    .d   (bundle_c),
    .q   (bundle_q)
  );

  assign {x, y, hsync, vsync, de, line_start, frame_start} = bundle_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: four generator instances checked every cycle against a raster-position model.
module tb_video_timing_gen;

  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int hpol; int vpol; int pd;
  } mode_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
  } vout_t;

  localparam mode_t MA = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 0};
  localparam mode_t MB = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 3};
  localparam mode_t MD = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0};

  logic clk = 1'b0;
  logic rst, en_m, en_c, chk_on;
  int   n_total = 0, n_pass = 0;
  int   ka = 0, kb = 0, kc = 0, kd = 0;

  logic [3:0] xa, xb, xc;
  logic [2:0] ya, yb, yc;
  logic [9:0] xd, yd;
  logic hsa, vsa, dea, lsa, fsa;
  logic hsb, vsb, deb, lsb, fsb;
  logic hsc, vsc, dec, lsc, fsc;
  logic hsd, vsd, ded, lsd, fsd;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(MA.ha), .H_FRONT(MA.hf), .H_SYNC(MA.hsw), .H_BACK(MA.hb),
    .V_ACTIVE(MA.va), .V_FRONT(MA.vf), .V_SYNC(MA.vsw), .V_BACK(MA.vb),
    .HSYNC_POL(MA.hpol), .VSYNC_POL(MA.vpol), .PIPE_DELAY(MA.pd)
  ) u_a (
    .pxl_clk(clk), .rst(rst), .en(en_m), .x(xa), .y(ya), .hsync(hsa), .vsync(vsa),
    .de(dea), .line_start(lsa), .frame_start(fsa)
  );

  video_timing_gen #(
    .H_ACTIVE(MB.ha), .H_FRONT(MB.hf), .H_SYNC(MB.hsw), .H_BACK(MB.hb),
    .V_ACTIVE(MB.va), .V_FRONT(MB.vf), .V_SYNC(MB.vsw), .V_BACK(MB.vb),
    .HSYNC_POL(MB.hpol), .VSYNC_POL(MB.vpol), .PIPE_DELAY(MB.pd)
  ) u_b (
    .pxl_clk(clk), .rst(rst), .en(en_m), .x(xb), .y(yb), .hsync(hsb), .vsync(vsb),
    .de(deb), .line_start(lsb), .frame_start(fsb)
  );

  // Same mode as u_a, driven with a pseudo-random enable
  video_timing_gen #(
    .H_ACTIVE(MA.ha), .H_FRONT(MA.hf), .H_SYNC(MA.hsw), .H_BACK(MA.hb),
    .V_ACTIVE(MA.va), .V_FRONT(MA.vf), .V_SYNC(MA.vsw), .V_BACK(MA.vb),
    .HSYNC_POL(MA.hpol), .VSYNC_POL(MA.vpol), .PIPE_DELAY(MA.pd)
  ) u_c (
    .pxl_clk(clk), .rst(rst), .en(en_c), .x(xc), .y(yc), .hsync(hsc), .vsync(vsc),
    .de(dec), .line_start(lsc), .frame_start(fsc)
  );

  video_timing_gen u_d (
    .pxl_clk(clk), .rst(rst), .en(en_m), .x(xd), .y(yd), .hsync(hsd), .vsync(vsd),
    .de(ded), .line_start(lsd), .frame_start(fsd)
  );

  // Expected outputs after k enabled clocks since reset, from the linear raster position
  function automatic vout_t model(input mode_t m, input int k);
    vout_t o;
    int ht, vt, p, px, py, vs0;
    ht   = m.ha + m.hf + m.hsw + m.hb;
    vt   = m.va + m.vf + m.vsw + m.vb;
    o.x  = '0;
    o.y  = '0;
    o.de = 1'b0;
    o.ls = 1'b0;
    o.fs = 1'b0;
    o.hs = (m.hpol == 0);
    o.vs = (m.vpol == 0);
    if (k >= 1 + m.pd) begin
      p  = (k - 1 - m.pd) % (ht * vt);
      px = p % ht;
      py = p / ht;
      o.x  = 16'(px);
      o.y  = 16'(py);
      o.de = (px < m.ha) && (py < m.va);
      o.ls = (px == 0);
      o.fs = (p == 0);
      o.hs = ((px >= m.ha + m.hf) && (px < m.ha + m.hf + m.hsw)) ? (m.hpol != 0) : (m.hpol == 0);
`ifdef VTG_VSYNC_HALIGN_EN
      vs0 = (m.va + m.vf) * ht + m.ha + m.hf;
`else
      vs0 = (m.va + m.vf) * ht;
`endif
      o.vs = ((p >= vs0) && (p < vs0 + m.vsw * ht)) ? (m.vpol != 0) : (m.vpol == 0);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
  endtask

  task automatic cmp(input string nm, input vout_t got, input vout_t want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                  nm, $time, got.x, got.y, got.hs, got.vs, got.de, got.ls, got.fs,
                  want.x, want.y, want.hs, want.vs, want.de, want.ls, want.fs);
  endtask

  // Enabled-clock counts since the last reset, one per instance
  always @(posedge clk) begin
    if (rst) begin
      ka <= 0; kb <= 0; kc <= 0; kd <= 0;
    end else begin
      if (en_m) begin
        ka <= ka + 1; kb <= kb + 1; kd <= kd + 1;
      end
      if (en_c) kc <= kc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_a", {16'(xa), 16'(ya), hsa, vsa, dea, lsa, fsa}, model(MA, ka));
      cmp("model_b", {16'(xb), 16'(yb), hsb, vsb, deb, lsb, fsb}, model(MB, kb));
      cmp("model_c", {16'(xc), 16'(yc), hsc, vsc, dec, lsc, fsc}, model(MA, kc));
      cmp("model_d", {16'(xd), 16'(yd), hsd, vsd, ded, lsd, fsd}, model(MD, kd));
    end
  end

  initial begin
    rst = 1'b1; en_m = 1'b1; en_c = 1'b0; chk_on = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset_a_hsync", hsa, 1);
    chk("reset_a_vsync", vsa, 1);
    chk("reset_a_de", dea, 0);
    chk("reset_b_hsync", hsb, 0);
    chk("reset_b_vsync", vsb, 0);
    chk("reset_d_x", xd, 0);
    rst = 1'b0; en_c = 1'b1;

    for (int c = 1; c <= 900; c++) begin
      @(negedge clk);
      en_c = 1'($urandom_range(0, 1));
      case (c)
        1: begin
          chk("a_first_frame_start", fsa, 1);
          chk("a_first_line_start", lsa, 1);
          chk("a_first_de", dea, 1);
          chk("b_frame_start_early", fsb, 0);
        end
        3:   chk("b_frame_start_c3", fsb, 0);
        4:   chk("b_frame_start_c4", fsb, 1);
        13:  chk("b_hsync_idle_low", hsb, 0);
        14:  chk("b_hsync_pulse_high", hsb, 1);
        15: begin
          chk("a_second_line_x", xa, 0);
          chk("a_second_line_y", ya, 1);
          chk("a_second_line_start", lsa, 1);
        end
`ifdef VTG_VSYNC_HALIGN_EN
        71:  chk("a_vsync_pos70", vsa, 1);
        91:  chk("a_vsync_pos90", vsa, 0);
`else
        71:  chk("a_vsync_pos70", vsa, 0);
        91:  chk("a_vsync_pos90", vsa, 1);
`endif
        98:  chk("a_frame_start_pos97", fsa, 0);
        99: begin
          chk("a_frame_start_period", fsa, 1);
          chk("a_wrap_x", xa, 0);
          chk("a_wrap_y", ya, 0);
        end
        640: chk("d_de_last_active", ded, 1);
        641: chk("d_de_first_blank", ded, 0);
        656: chk("d_hsync_before", hsd, 1);
        657: begin
          chk("d_hsync_fall", hsd, 0);
          chk("d_hsync_fall_x", xd, 656);
        end
        752: chk("d_hsync_last_low", hsd, 0);
        753: chk("d_hsync_rise", hsd, 1);
        default: ;
      endcase
    end

    // Mid-frame reset with enable low: reset must still win
    rst = 1'b1; en_c = 1'b0;
    @(negedge clk);
    chk("midrst_a_x", xa, 0);
    chk("midrst_a_hsync", hsa, 1);
    chk("midrst_b_hsync", hsb, 0);
    chk("midrst_d_x", xd, 0);
    chk("midrst_d_de", ded, 0);
    rst = 1'b0; en_c = 1'b1;

    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      en_c = 1'($urandom_range(0, 1));
      case (c)
        1:  chk("midrst_a_frame_start", fsa, 1);
        3:  chk("midrst_b_frame_start_c3", fsb, 0);
        4:  chk("midrst_b_frame_start_c4", fsb, 1);
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
